// File: rtl/dm_arbiter.sv
// Round-robin arbiter between CPU (A) and DMA (B) ports feeding the single dm_4k access port.
// Latency: req in IDLE at cycle t -> one-cycle ack at t+2; one transaction every 3 cycles.
// Backpressure: a requester holds req until its ack; requests are sampled only in IDLE.
module dm_arbiter #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              a_req,
    input  logic              a_wr,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_din,
    input  logic [1:0]        a_byteExt,
    output logic              a_ack,
    output logic [DATA_W-1:0] a_rdata,

    input  logic              b_req,
    input  logic              b_wr,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_din,
    input  logic [1:0]        b_byteExt,
    output logic              b_ack,
    output logic [DATA_W-1:0] b_rdata,

    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_din,
    output logic [1:0]        m_byteExt,
    output logic [1:0]        m_wEn,
    input  logic [DATA_W-1:0] m_dout,

    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        ACK    = 2'd2
    } state_t;

    // Port encoding for owner/last: 0 = A, 1 = B.
    state_t              state_q, state_d;
    logic                last_q, last_d;
    logic                owner_q, owner_d;
    logic                wr_q, wr_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   din_q, din_d;
    logic [1:0]          bext_q, bext_d;
    logic [DATA_W-1:0]   a_rdata_q, a_rdata_d;
    logic [DATA_W-1:0]   b_rdata_q, b_rdata_d;
    logic                grant_b;

    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        owner_d   = owner_q;
        wr_d      = wr_q;
        addr_d    = addr_q;
        din_d     = din_q;
        bext_d    = bext_q;
        a_rdata_d = a_rdata_q;
        b_rdata_d = b_rdata_q;
        // On a tie B wins only if A was served last.
        grant_b   = b_req & (~a_req | ~last_q);

        case (state_q)
            IDLE: begin
                if (a_req | b_req) begin
                    owner_d = grant_b;
                    last_d  = grant_b;
                    wr_d    = grant_b ? b_wr      : a_wr;
                    addr_d  = grant_b ? b_addr    : a_addr;
                    din_d   = grant_b ? b_din     : a_din;
                    bext_d  = grant_b ? b_byteExt : a_byteExt;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (!wr_q) begin
                    if (owner_q) begin
                        b_rdata_d = m_dout;
                    end else begin
                        a_rdata_d = m_dout;
                    end
                end
                state_d = ACK;
            end
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            last_q    <= 1'b1;
            owner_q   <= 1'b0;
            wr_q      <= 1'b0;
            addr_q    <= '0;
            din_q     <= '0;
            bext_q    <= 2'b00;
            a_rdata_q <= '0;
            b_rdata_q <= '0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            owner_q   <= owner_d;
            wr_q      <= wr_d;
            addr_q    <= addr_d;
            din_q     <= din_d;
            bext_q    <= bext_d;
            a_rdata_q <= a_rdata_d;
            b_rdata_q <= b_rdata_d;
        end
    end

    // Write enable and acks are gated by rst so a reset aborts the access without a write or pulse.
    assign m_addr    = addr_q;
    assign m_din     = din_q;
    assign m_byteExt = bext_q;
    assign m_wEn     = (state_q == ACCESS && wr_q && !rst) ? 2'b01 : 2'b00;
    assign a_ack     = (state_q == ACK) && !owner_q && !rst;
    assign b_ack     = (state_q == ACK) &&  owner_q && !rst;
    assign a_rdata   = a_rdata_q;
    assign b_rdata   = b_rdata_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_dm_arbiter.sv
// Bench for dm_arbiter with a behavioural big-endian dm_4k and an ack scoreboard.
module tb_dm_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        a_req, a_wr, b_req, b_wr;
    logic [11:0] a_addr, b_addr;
    logic [31:0] a_din, b_din;
    logic [1:0]  a_byteExt, b_byteExt;
    logic        a_ack, b_ack;
    logic [31:0] a_rdata, b_rdata;
    logic [11:0] m_addr;
    logic [31:0] m_din, m_dout;
    logic [1:0]  m_byteExt, m_wEn;
    logic        busy;

    dm_arbiter #(.ADDR_W(12), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .a_req(a_req), .a_wr(a_wr), .a_addr(a_addr), .a_din(a_din),
        .a_byteExt(a_byteExt), .a_ack(a_ack), .a_rdata(a_rdata),
        .b_req(b_req), .b_wr(b_wr), .b_addr(b_addr), .b_din(b_din),
        .b_byteExt(b_byteExt), .b_ack(b_ack), .b_rdata(b_rdata),
        .m_addr(m_addr), .m_din(m_din), .m_byteExt(m_byteExt),
        .m_wEn(m_wEn), .m_dout(m_dout), .busy(busy)
    );

    always #5 clk = ~clk;

    // dm_4k model: byte 0 of a word is bits 31:24; byteExt 01 sign-extends a byte load, 10 stores a byte.
    logic [31:0] mem [0:1023];
    logic [31:0] rd_word;
    logic [7:0]  rd_byte;
    always_comb begin
        rd_word = mem[m_addr[11:2]];
        rd_byte = rd_word[8*(3-m_addr[1:0]) +: 8];
        m_dout  = (m_byteExt == 2'b01) ? {{24{rd_byte[7]}}, rd_byte} : rd_word;
    end
    always @(posedge clk) begin
        if (m_wEn == 2'b01) begin
            if (m_byteExt == 2'b10)
                mem[m_addr[11:2]][8*(3-m_addr[1:0]) +: 8] <= m_din[7:0];
            else
                mem[m_addr[11:2]] <= m_din;
        end
    end

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;
    int wen_cnt      = 0;

    typedef struct {
        bit          port;
        logic [31:0] rd;
        int          cyc;
    } exp_t;
    exp_t        sb[$];
    logic [31:0] hold [2];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Every ack must match the head of the scoreboard in port, cycle and read data.
    always @(negedge clk) begin
        if (m_wEn == 2'b01) wen_cnt <= wen_cnt + 1;
        if (a_ack && b_ack) check("dual_ack", 32'd1, 32'd0);
        else if (a_ack || b_ack) begin
            if (sb.size() == 0) check("unexpected_ack", {31'd0, b_ack}, 32'hFFFF_FFFF);
            else begin
                exp_t e;
                e = sb.pop_front();
                check("ack_port", {31'd0, b_ack}, {31'd0, e.port});
                check("ack_cycle", cyc, e.cyc);
                check("rdata", b_ack ? b_rdata : a_rdata, e.rd);
            end
        end
    end

    task automatic drive(input bit port, input bit req, input bit wr, input logic [11:0] addr,
                         input logic [31:0] din, input logic [1:0] bext);
        if (port) begin
            b_req = req; b_wr = wr; b_addr = addr; b_din = din; b_byteExt = bext;
        end else begin
            a_req = req; a_wr = wr; a_addr = addr; a_din = din; a_byteExt = bext;
        end
    endtask

    // Called just after a posedge with the DUT in IDLE; returns just after the posedge that ends ACK.
    task automatic xact(input bit port, input bit wr, input logic [11:0] addr,
                        input logic [31:0] din, input logic [1:0] bext, input logic [31:0] ld_exp);
        bit seen = 0;
        if (!wr) hold[port] = ld_exp;
        sb.push_back('{port: port, rd: hold[port], cyc: cyc + 2});
        drive(port, 1'b1, wr, addr, din, bext);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (port ? b_ack : a_ack) begin
                seen = 1;
                break;
            end
        end
        if (!seen) check("ack_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        drive(port, 1'b0, 1'b0, 12'h0, 32'h0, 2'b00);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int c0;
        int w0;
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        hold[0] = 32'h0;
        hold[1] = 32'h0;
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 12'h0, 32'h0, 2'b00);
        drive(1'b1, 1'b0, 1'b0, 12'h0, 32'h0, 2'b00);

        // Reset then idle
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_a_rdata", a_rdata, 32'h0);
        check("rst_b_rdata", b_rdata, 32'h0);
        check("rst_m_bus", {m_addr, m_byteExt}, 32'h0);
        check("rst_m_din", m_din, 32'h0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("idle_quiet", {28'd0, busy, a_ack, b_ack, |m_wEn}, 32'h0);
        end
        @(posedge clk); #1;

        // A store then A load
        w0 = wen_cnt;
        xact(1'b0, 1'b1, 12'h010, 32'hDEADBEEF, 2'b00, 32'h0);
        check("store_wen_pulses", wen_cnt - w0, 32'd1);
        w0 = wen_cnt;
        xact(1'b0, 1'b0, 12'h010, 32'h0, 2'b00, 32'hDEADBEEF);
        check("load_wen_pulses", wen_cnt - w0, 32'd0);

        // Byte path via B, observed from A
        xact(1'b1, 1'b1, 12'h010, 32'h11223344, 2'b00, 32'h0);
        xact(1'b1, 1'b1, 12'h013, 32'h000000AA, 2'b10, 32'h0);
        xact(1'b0, 1'b0, 12'h010, 32'h0, 2'b00, 32'h112233AA);
        xact(1'b1, 1'b0, 12'h013, 32'h0, 2'b01, 32'hFFFFFFAA);
        xact(1'b0, 1'b1, 12'h004, 32'h0BADF00D, 2'b00, 32'h0);
        check("a_rdata_held_after_store", a_rdata, 32'h112233AA);

        // Contention from reset: A,B,A,B acks at c0+2,5,8,11
        rst = 1'b1;
        drive(1'b0, 1'b1, 1'b0, 12'h010, 32'h0, 2'b00);
        drive(1'b1, 1'b1, 1'b0, 12'h004, 32'h0, 2'b00);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        c0 = cyc;
        hold[0] = 32'h112233AA;
        hold[1] = 32'h0BADF00D;
        sb.push_back('{port: 1'b0, rd: 32'h112233AA, cyc: c0 + 2});
        sb.push_back('{port: 1'b1, rd: 32'h0BADF00D, cyc: c0 + 5});
        sb.push_back('{port: 1'b0, rd: 32'h112233AA, cyc: c0 + 8});
        sb.push_back('{port: 1'b1, rd: 32'h0BADF00D, cyc: c0 + 11});
        repeat (12) @(posedge clk);
        #1;
        drive(1'b0, 1'b0, 1'b0, 12'h0, 32'h0, 2'b00);
        drive(1'b1, 1'b0, 1'b0, 12'h0, 32'h0, 2'b00);
        repeat (3) @(posedge clk);
        #1;
        check("contention_drained", sb.size(), 32'd0);

        // Reset during the ACCESS cycle of a store
        drive(1'b0, 1'b1, 1'b1, 12'h020, 32'hCAFEF00D, 2'b00);
        @(posedge clk); #1;
        check("access_wen", {30'd0, m_wEn}, 32'd1);
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 12'h0, 32'h0, 2'b00);
        #1;
        check("rst_kills_wen", {30'd0, m_wEn}, 32'd0);
        check("rst_access_addr", {20'd0, m_addr}, 32'h020);
        @(posedge clk); #1;
        rst = 1'b0;
        hold[0] = 32'h0;
        hold[1] = 32'h0;
        check("post_rst_busy", {31'd0, busy}, 32'd0);
        check("post_rst_a_rdata", a_rdata, 32'h0);
        check("post_rst_m_addr", {20'd0, m_addr}, 32'h0);
        xact(1'b0, 1'b0, 12'h020, 32'h0, 2'b00, 32'h0);

        // Late drop: req held through the IDLE after ack -> second transaction
        c0 = cyc;
        hold[0] = 32'h0BADF00D;
        sb.push_back('{port: 1'b0, rd: 32'h0BADF00D, cyc: c0 + 2});
        sb.push_back('{port: 1'b0, rd: 32'h0BADF00D, cyc: c0 + 5});
        drive(1'b0, 1'b1, 1'b0, 12'h004, 32'h0, 2'b00);
        repeat (4) @(posedge clk);
        #1;
        drive(1'b0, 1'b0, 1'b0, 12'h0, 32'h0, 2'b00);
        repeat (4) @(posedge clk);
        #1;
        check("late_drop_drained", sb.size(), 32'd0);
        check("final_idle", {31'd0, busy}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
